// File: rtl/countdown_timer_bcd_if.sv
// countdown_timer_bcd_if
//   Bundles the control strobes, preset and status of countdown_timer_bcd.
//   master : drives tick/start/pause/load/preset, observes digits/running/done/zero
//   slave  : the timer itself
// Parameter NUM_DIGITS must match the NUM_DIGITS of the attached timer.
interface countdown_timer_bcd_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    tick;
  logic                    start;
  logic                    pause;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] preset;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    running;
  logic                    done;
  logic                    zero;

  modport master (
    output tick, start, pause, load, preset,
    input  digits, running, done, zero
  );

  modport slave (
    input  tick, start, pause, load, preset,
    output digits, running, done, zero
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd
//   Multi-digit BCD down-counter with IDLE/RUN/PAUSED/DONE control.
//   Per-cycle priority: reset > load > pause > start > tick.
// Ports:
//   i_clk  : clock, all state changes on rising edge
//   i_rst  : synchronous active-high reset
//   bus    : countdown_timer_bcd_if.slave
//            in : tick, start, pause, load, preset[4*NUM_DIGITS]
//            out: digits (registered), running (registered),
//                 done (registered one-cycle pulse), zero (decode of digits)
// Parameters:
//   NUM_DIGITS : 2..8 BCD digits, digit 0 in bits [3:0]
//   TIME_MODE  : 1 = odd digits count 5..0 (mm:ss), 0 = all digits 9..0
// Build option:
//   COUNTDOWN_AUTO_RELOAD_EN : on reaching zero in RUN, reload the last
//   loaded preset and keep running instead of entering DONE.
//
// state  | meaning
// IDLE   | stopped, waiting for start (ignored while count is zero)
// RUN    | decrementing once per tick
// PAUSED | count frozen, start resumes
// DONE   | reached zero, holds until load or reset
module countdown_timer_bcd #(
  parameter int NUM_DIGITS = 4,
  parameter int TIME_MODE  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  countdown_timer_bcd_if.slave bus
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [W-1:0]   r_digits;
  logic [W-1:0]   w_next_digits;
  logic [W-1:0]   w_clamped;
  logic [W-1:0]   w_dec;
  logic           r_running;
  logic           r_done;
  logic           w_next_done;
  logic           w_zero;
  logic           w_dec_zero;

  function automatic logic [3:0] digit_limit(input int idx);
    return ((TIME_MODE == 1) && ((idx % 2) == 1)) ? 4'd5 : 4'd9;
  endfunction

  // Out-of-range preset digits saturate at the digit's own limit.
  always_comb begin
    w_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.preset[4*i +: 4] > digit_limit(i))
        w_clamped[4*i +: 4] = digit_limit(i);
      else
        w_clamped[4*i +: 4] = bus.preset[4*i +: 4];
    end
  end

  // Full ripple borrow: a zero digit receiving a borrow wraps to its limit
  // and passes the borrow on; the first non-zero digit absorbs it.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    w_dec  = r_digits;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (r_digits[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = digit_limit(i);
        end else begin
          w_dec[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  assign w_zero     = (r_digits == '0);
  assign w_dec_zero = (w_dec == '0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [W-1:0] r_shadow;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_shadow <= '0;
    else if (bus.load)
      r_shadow <= w_clamped;
  end
`endif

  always_comb begin
    w_next_state  = r_state;
    w_next_digits = r_digits;
    w_next_done   = 1'b0;
    if (bus.load) begin
      w_next_digits = w_clamped;
      w_next_state  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.pause && bus.start && !w_zero)
            w_next_state = S_RUN;
        end
        S_RUN: begin
          if (bus.pause) begin
            w_next_state = S_PAUSED;
          end else if (bus.tick && !w_zero) begin
            w_next_digits = w_dec;
            if (w_dec_zero) begin
              w_next_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              // A zero shadow would loop forever on nothing; stop instead.
              if (r_shadow != '0)
                w_next_digits = r_shadow;
              else
                w_next_state = S_DONE;
`else
              w_next_state = S_DONE;
`endif
            end
          end
        end
        S_PAUSED: begin
          if (!bus.pause && bus.start)
            w_next_state = S_RUN;
        end
        S_DONE: begin
          w_next_state = S_DONE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_digits  <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_digits  <= w_next_digits;
      r_running <= (w_next_state == S_RUN);
      r_done    <= w_next_done;
    end
  end

  assign bus.digits  = r_digits;
  assign bus.running = r_running;
  assign bus.done    = r_done;
  assign bus.zero    = w_zero;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
module tb_countdown_timer_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  countdown_timer_bcd_if #(.NUM_DIGITS(4)) bus_t ();
  countdown_timer_bcd_if #(.NUM_DIGITS(4)) bus_d ();

  assign bus_t.tick = tick;   assign bus_d.tick = tick;
  assign bus_t.start = start; assign bus_d.start = start;
  assign bus_t.pause = pause; assign bus_d.pause = pause;
  assign bus_t.load = load;   assign bus_d.load = load;
  assign bus_t.preset = preset; assign bus_d.preset = preset;

  countdown_timer_bcd #(.NUM_DIGITS(4), .TIME_MODE(1)) u_dut_t (
    .i_clk(clk), .i_rst(rst), .bus(bus_t)
  );
  countdown_timer_bcd #(.NUM_DIGITS(4), .TIME_MODE(0)) u_dut_d (
    .i_clk(clk), .i_rst(rst), .bus(bus_d)
  );

  // index 0 = decimal instance, index 1 = mm:ss instance
  logic [15:0] dut_digits [2];
  logic        dut_run    [2];
  logic        dut_done   [2];
  logic        dut_zero   [2];
  assign dut_digits[0] = bus_d.digits;  assign dut_digits[1] = bus_t.digits;
  assign dut_run[0]    = bus_d.running; assign dut_run[1]    = bus_t.running;
  assign dut_done[0]   = bus_d.done;    assign dut_done[1]   = bus_t.done;
  assign dut_zero[0]   = bus_d.zero;    assign dut_zero[1]   = bus_t.zero;

  // Reference model: the count is a plain integer in a mixed-radix system.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_val    [2];
  int m_shadow [2];
  int m_state  [2];
  bit m_done   [2];

  function automatic int radix(input int mode, input int i);
    return (mode == 1 && (i % 2) == 1) ? 6 : 10;
  endfunction

  function automatic int to_total(input logic [15:0] v, input int mode);
    int total, w, d;
    total = 0; w = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > radix(mode, i) - 1) d = radix(mode, i) - 1;
      total += d * w;
      w *= radix(mode, i);
    end
    return total;
  endfunction

  function automatic logic [15:0] to_bcd(input int t, input int mode);
    logic [15:0] r;
    int          d;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      d = t % radix(mode, i);
      t = t / radix(mode, i);
      r[4*i +: 4] = 4'(d);
    end
    return r;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      m_done[m] = 1'b0;
      if (rst) begin
        m_val[m] = 0; m_shadow[m] = 0; m_state[m] = M_IDLE;
      end else if (load) begin
        m_val[m] = to_total(preset, m);
        m_shadow[m] = m_val[m];
        m_state[m] = M_IDLE;
      end else begin
        case (m_state[m])
          M_IDLE:   if (!pause && start && m_val[m] != 0) m_state[m] = M_RUN;
          M_PAUSED: if (!pause && start) m_state[m] = M_RUN;
          M_RUN: begin
            if (pause) m_state[m] = M_PAUSED;
            else if (tick && m_val[m] > 0) begin
              m_val[m] = m_val[m] - 1;
              if (m_val[m] == 0) begin
                m_done[m] = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (m_shadow[m] != 0) m_val[m] = m_shadow[m];
                else m_state[m] = M_DONE;
`else
                m_state[m] = M_DONE;
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic p, input logic s,
                     input logic t, input logic [15:0] pr);
    rst = r; load = l; pause = p; start = s; tick = t; preset = pr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 0; load = 0; pause = 0; start = 0; tick = 0;
  endtask

  task automatic test_reset();
    cyc(1, 1, 0, 1, 1, 16'h1234);
    for (int m = 0; m < 2; m++) begin
      n_tests++; if (dut_digits[m] !== 16'h0000) begin n_fail++; $display("FAIL reset_digits[%0d]: got %h want 0000", m, dut_digits[m]); end
      n_tests++; if (dut_run[m] !== 1'b0) begin n_fail++; $display("FAIL reset_running[%0d]: got %b want 0", m, dut_run[m]); end
      n_tests++; if (dut_done[m] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", m, dut_done[m]); end
      n_tests++; if (dut_zero[m] !== 1'b1) begin n_fail++; $display("FAIL reset_zero[%0d]: got %b want 1", m, dut_zero[m]); end
    end
  endtask

  task automatic test_mmss();
    cyc(0, 1, 0, 0, 0, 16'h0100);
    cyc(0, 0, 0, 1, 0, 16'h0);
    n_tests++; if (bus_t.running !== 1'b1) begin n_fail++; $display("FAIL mmss_start_running: got %b want 1", bus_t.running); end
    cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.digits !== 16'h0059) begin n_fail++; $display("FAIL mmss_first_tick: got %h want 0059", bus_t.digits); end
    for (int i = 0; i < 58; i++) begin
      cyc(0, 0, 0, 0, 1, 16'h0);
      n_tests++; if (bus_t.done !== 1'b0) begin n_fail++; $display("FAIL mmss_early_done: tick %0d got %b want 0", i, bus_t.done); end
    end
    n_tests++; if (bus_t.digits !== 16'h0001) begin n_fail++; $display("FAIL mmss_before_last: got %h want 0001", bus_t.digits); end
    cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.done !== 1'b1) begin n_fail++; $display("FAIL mmss_done_pulse: got %b want 1", bus_t.done); end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    n_tests++; if (bus_t.digits !== 16'h0100) begin n_fail++; $display("FAIL mmss_reload: got %h want 0100", bus_t.digits); end
    n_tests++; if (bus_t.running !== 1'b1) begin n_fail++; $display("FAIL mmss_reload_running: got %b want 1", bus_t.running); end
`else
    n_tests++; if (bus_t.digits !== 16'h0000) begin n_fail++; $display("FAIL mmss_final_digits: got %h want 0000", bus_t.digits); end
    n_tests++; if (bus_t.running !== 1'b0) begin n_fail++; $display("FAIL mmss_done_running: got %b want 0", bus_t.running); end
    cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.done !== 1'b0) begin n_fail++; $display("FAIL mmss_done_width: got %b want 0", bus_t.done); end
    n_tests++; if (bus_t.digits !== 16'h0000) begin n_fail++; $display("FAIL mmss_no_underflow: got %h want 0000", bus_t.digits); end
    cyc(0, 0, 0, 1, 1, 16'h0);
    n_tests++; if (bus_t.running !== 1'b0) begin n_fail++; $display("FAIL mmss_start_in_done: got %b want 0", bus_t.running); end
`endif
  endtask

  task automatic test_decimal();
    cyc(0, 1, 0, 0, 0, 16'h1000);
    cyc(0, 0, 0, 1, 0, 16'h0);
    cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_d.digits !== 16'h0999) begin n_fail++; $display("FAIL dec_borrow: got %h want 0999", bus_d.digits); end
    n_tests++; if (bus_t.digits !== 16'h0959) begin n_fail++; $display("FAIL mmss_borrow: got %h want 0959", bus_t.digits); end
    cyc(0, 1, 0, 0, 0, 16'h1000);
    cyc(0, 0, 0, 1, 1, 16'h0);
    n_tests++; if (bus_d.digits !== 16'h1000) begin n_fail++; $display("FAIL dec_start_tick: got %h want 1000", bus_d.digits); end
    n_tests++; if (bus_d.running !== 1'b1) begin n_fail++; $display("FAIL dec_start_running: got %b want 1", bus_d.running); end
  endtask

  task automatic test_pause();
    cyc(0, 1, 0, 0, 0, 16'h0042);
    cyc(0, 0, 0, 1, 0, 16'h0);
    cyc(0, 0, 1, 1, 1, 16'h0);
    n_tests++; if (bus_t.running !== 1'b0) begin n_fail++; $display("FAIL pause_wins: got %b want 0", bus_t.running); end
    n_tests++; if (bus_t.digits !== 16'h0042) begin n_fail++; $display("FAIL pause_tick_same_cycle: got %h want 0042", bus_t.digits); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.digits !== 16'h0042) begin n_fail++; $display("FAIL paused_hold: got %h want 0042", bus_t.digits); end
    cyc(0, 0, 0, 1, 1, 16'h0);
    n_tests++; if (bus_t.running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %b want 1", bus_t.running); end
    n_tests++; if (bus_t.digits !== 16'h0042) begin n_fail++; $display("FAIL resume_no_dec: got %h want 0042", bus_t.digits); end
    cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.digits !== 16'h0041) begin n_fail++; $display("FAIL resume_tick: got %h want 0041", bus_t.digits); end
  endtask

  task automatic test_zero_clamp();
    cyc(0, 1, 0, 0, 0, 16'h0000);
    cyc(0, 0, 0, 1, 0, 16'h0);
    n_tests++; if (bus_t.running !== 1'b0) begin n_fail++; $display("FAIL zero_start_running: got %b want 0", bus_t.running); end
    n_tests++; if (bus_t.zero !== 1'b1) begin n_fail++; $display("FAIL zero_flag: got %b want 1", bus_t.zero); end
    cyc(0, 1, 0, 0, 0, 16'h9999);
    n_tests++; if (bus_t.digits !== 16'h5959) begin n_fail++; $display("FAIL clamp_mmss: got %h want 5959", bus_t.digits); end
    n_tests++; if (bus_d.digits !== 16'h9999) begin n_fail++; $display("FAIL clamp_dec: got %h want 9999", bus_d.digits); end
    cyc(0, 1, 0, 0, 0, 16'h0005);
    cyc(0, 0, 0, 1, 0, 16'h0);
    cyc(0, 1, 0, 0, 1, 16'h0005);
    n_tests++; if (bus_t.digits !== 16'h0005) begin n_fail++; $display("FAIL load_ignores_tick: got %h want 0005", bus_t.digits); end
    n_tests++; if (bus_t.running !== 1'b0) begin n_fail++; $display("FAIL load_to_idle: got %b want 0", bus_t.running); end
  endtask

  task automatic test_reset_mid_run();
    cyc(0, 1, 0, 0, 0, 16'h0010);
    cyc(0, 0, 0, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.digits !== 16'h0007) begin n_fail++; $display("FAIL run_to_7: got %h want 0007", bus_t.digits); end
    cyc(1, 0, 0, 1, 1, 16'h0);
    n_tests++; if (bus_t.digits !== 16'h0000) begin n_fail++; $display("FAIL rst_digits: got %h want 0000", bus_t.digits); end
    n_tests++; if (bus_t.running !== 1'b0) begin n_fail++; $display("FAIL rst_running: got %b want 0", bus_t.running); end
    n_tests++; if (bus_t.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus_t.done); end
    cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.done !== 1'b0) begin n_fail++; $display("FAIL rst_no_late_done: got %b want 0", bus_t.done); end
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    cyc(0, 1, 0, 0, 0, 16'h0002);
    cyc(0, 0, 0, 1, 0, 16'h0);
    cyc(0, 0, 0, 0, 1, 16'h0);
    cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.done !== 1'b1) begin n_fail++; $display("FAIL reach_done: got %b want 1", bus_t.done); end
    cyc(0, 1, 0, 0, 0, 16'h0123);
    n_tests++; if (bus_t.digits !== 16'h0123) begin n_fail++; $display("FAIL load_in_done: got %h want 0123", bus_t.digits); end
    cyc(0, 0, 0, 1, 0, 16'h0);
    n_tests++; if (bus_t.running !== 1'b1) begin n_fail++; $display("FAIL start_after_done_load: got %b want 1", bus_t.running); end
`endif
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    cyc(0, 1, 0, 0, 0, 16'h0003);
    cyc(0, 0, 0, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 16'h0);
    n_tests++; if (bus_t.done !== 1'b1) begin n_fail++; $display("FAIL reload_done: got %b want 1", bus_t.done); end
    n_tests++; if (bus_t.digits !== 16'h0003) begin n_fail++; $display("FAIL reload_digits: got %h want 0003", bus_t.digits); end
    n_tests++; if (bus_t.running !== 1'b1) begin n_fail++; $display("FAIL reload_running: got %b want 1", bus_t.running); end
  endtask
`endif

  task automatic test_random();
    logic [15:0] pr;
    logic        r, l, p, s, t;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 4) == 0);
      t = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 3) pr = 16'($urandom_range(0, 65535));
      else pr = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      cyc(r, l, p, s, t, pr);
      for (int m = 0; m < 2; m++) begin
        n_tests++;
        if (dut_digits[m] !== to_bcd(m_val[m], m) || dut_run[m] !== (m_state[m] == M_RUN) ||
            dut_done[m] !== m_done[m] || dut_zero[m] !== (m_val[m] == 0)) begin
          n_fail++;
          $display("FAIL random[%0d] cycle %0d: got digits=%h run=%b done=%b zero=%b want digits=%h run=%b done=%b zero=%b",
                   m, c, dut_digits[m], dut_run[m], dut_done[m], dut_zero[m],
                   to_bcd(m_val[m], m), (m_state[m] == M_RUN), m_done[m], (m_val[m] == 0));
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_val[m] = 0; m_shadow[m] = 0; m_state[m] = M_IDLE; m_done[m] = 1'b0;
    end
    test_reset();
    test_mmss();
    test_decimal();
    test_pause();
    test_zero_clamp();
    test_reset_mid_run();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    cyc(1, 0, 0, 0, 0, 16'h0);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer_bcd.md
COUNTDOWN_TIMER_BCD -- requirements
Module: countdown_timer_bcd

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD digits (legal range 2..8).
REQ-002 The block SHALL have parameter TIME_MODE, default 1: 1 = odd-index digits (1,3,5,7) count 5..0 and even-index digits count 9..0 (mm:ss style); 0 = all digits count 9..0.
REQ-003 clk  input  1  single global clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick  input  1  count strobe, one-cycle pulse; one decrement per strobe while running.
REQ-006 start  input  1  start or resume request, sampled each cycle.
REQ-007 pause  input  1  pause request, sampled each cycle.
REQ-008 load  input  1  load preset into the counter and return to IDLE.
REQ-009 preset  input  4*NUM_DIGITS  BCD preset value; digit 0 occupies bits [3:0].
REQ-010 digits  output  4*NUM_DIGITS  current BCD count value, registered.
REQ-011 running  output  1  high while in RUN state, registered.
REQ-012 done  output  1  one-cycle pulse when the count reaches zero from RUN, registered.
REQ-013 zero  output  1  high whenever every digit equals 0 (combinational decode of the digits register).

Function
REQ-014 The FSM SHALL have four states, IDLE, RUN, PAUSED and DONE, with the following priority each cycle: rst > load > pause > start > tick.
REQ-015 On load, in any state, the block SHALL copy preset into the digits register (digit i greater than its limit is clamped to the limit) and enter IDLE on the next edge; tick is ignored in that cycle.
REQ-016 On start in IDLE with zero low, the block SHALL enter RUN; with zero high it SHALL remain in IDLE.
REQ-017 On start in PAUSED, the block SHALL enter RUN; start in RUN is a no-op; start in DONE is ignored.
REQ-018 On pause in RUN, the block SHALL enter PAUSED; when start and pause are both high, pause wins; pause in other states is a no-op.
REQ-019 Decrement SHALL occur only when state is RUN and tick=1 at the edge, with zero latency: the new value is visible in digits after that edge.
REQ-020 A tick in the same cycle as start from IDLE or PAUSED SHALL NOT decrement.
REQ-021 Decrement SHALL ripple a full borrow chain within one cycle: a digit at 0 with an incoming borrow wraps to its limit (9 or 5) and borrows from the next digit.
REQ-022 The count SHALL never underflow below all-zero.
REQ-023 When a decrement makes the count all-zero, the block SHALL enter DONE on the same edge, and done SHALL be high for exactly that following cycle.
REQ-024 In DONE, digits SHALL hold at zero and running SHALL be 0.
REQ-025 running SHALL equal (state==RUN) and SHALL update on the same edge as the state.

Reset
REQ-026 When rst=1 at an edge, digits SHALL be set to all-zero, the state to IDLE, and running and done to 0, regardless of the other inputs.
REQ-027 Reset asserted mid-RUN SHALL discard the count; no done pulse SHALL be produced.

Configuration
REQ-028 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL select the reload feature.
REQ-029 With COUNTDOWN_AUTO_RELOAD_EN defined, reaching zero in RUN SHALL pulse done for one cycle and, on the same edge, reload the last loaded preset (held in an internal register) and stay in RUN; DONE is unreachable from RUN except when the stored preset is zero.
REQ-030 Without COUNTDOWN_AUTO_RELOAD_EN, REQ-023 and REQ-024 apply, and no preset shadow register SHALL be synthesised.

Verification
REQ-031 With NUM_DIGITS=4 and TIME_MODE=1: load 0100, start, then 1 tick -> digits=0059; after 59 more ticks -> 0000, done pulses exactly 1 cycle, and the state is DONE.
REQ-032 With TIME_MODE=0: load 1000, start, 1 tick -> 0999; start and tick in the same cycle from IDLE -> no decrement.
REQ-033 In RUN at 0042: pause and start asserted together -> PAUSED, and ticks leave 0042; then start -> RUN, and the next tick gives 0041.
REQ-034 Load 0000, then start -> remains IDLE with running=0 and zero=1; load 9999 with TIME_MODE=1 -> digits=5959 (clamped).
REQ-035 rst asserted at 0007 in RUN -> next cycle digits=0000, IDLE, done=0; load asserted in DONE -> IDLE with the preset applied.
REQ-036 With COUNTDOWN_AUTO_RELOAD_EN defined: load 0003, start, 3 ticks -> done pulse, digits=0003, running stays 1.
